dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, wait states between acceptance and response (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  1  access request from the memory stage.
REQ-006 req_ready_o  output  1  responder can accept a request this cycle.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_we_i  input  1  1 = store, 0 = load.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 req_size_i  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 req_unsigned_i  input  1  1 = zero-extend load, 0 = sign-extend.
REQ-012 resp_valid_o  output  1  one-cycle response strobe.
REQ-013 resp_data_o  output  32  extended load data; 0 for stores.
REQ-014 resp_err_o  output  1  access faulted; qualified by resp_valid_o.
REQ-015 busy_o  output  1  a request is in flight (state != IDLE).

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-017 Handshake: request accepted on a rising edge with req_valid_i=1 and req_ready_o=1; addr, we, wdata, size, unsigned latched at acceptance; later input changes ignored.
REQ-018 IDLE->WAIT on acceptance when WAIT_CYCLES>0, else IDLE->RESP directly.
REQ-019 WAIT: down-counter loaded with WAIT_CYCLES-1 at acceptance; WAIT->RESP when counter is 0.
REQ-020 RESP: resp_valid_o=1 for exactly one cycle, then RESP->IDLE unconditionally; latency acceptance-edge to resp_valid_o = WAIT_CYCLES+1 cycles.
REQ-021 Word index = latched addr[31:2] modulo DEPTH_WORDS (wraps silently; no error).
REQ-022 Load: byte lane selected by addr[1:0], half by addr[1]; result extended per req_unsigned_i to 32 bits.
REQ-023 Store: array written on the edge leaving RESP, only byte lanes covered by size at addr[1:0]; other lanes unchanged.
REQ-024 Store followed by load to same word SHALL return the stored data (no stale read).
REQ-025 Outside RESP: resp_valid_o=0, resp_data_o=0, resp_err_o=0.
REQ-026 Maximum throughput: one access per WAIT_CYCLES+2 cycles; requests during non-IDLE states are stalled, not dropped.

Reset
REQ-027 rst=1 SHALL force IDLE immediately: req_ready_o=1 (once rst deasserts), resp_valid_o=0, resp_data_o=0, resp_err_o=0, busy_o=0, counter=0.
REQ-028 Reset mid-access aborts it: no response, no array write if the write edge had not occurred.
REQ-029 Array contents are not reset.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL give resp_err_o=1, resp_data_o=0, and suppress the store write.
REQ-031 Macro undefined: offending low address bits ignored (half uses addr[1], word uses addr[1:0]=00); resp_err_o tied 0.

Verification
REQ-032 WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_valid_o 2 cycles after each acceptance, load data 0xDEADBEEF.
REQ-033 After REQ-032: store byte 0x80 @0x11, load byte signed @0x11 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word @0x10 -> 0xDEAD80EF.
REQ-034 req_valid_i held high 5 back-to-back loads, WAIT_CYCLES=0 -> acceptances every 2 cycles, 5 resp_valid_o pulses, none lost.
REQ-035 DEPTH_WORDS=1024: store word 0x12345678 @0x1000, load @0x0 -> 0x12345678 (wrap).
REQ-036 With DMEM_ALIGN_CHECK_EN: store word 0xFFFFFFFF @0x22 -> resp_err_o=1; load word @0x20 returns prior value; without macro the same store writes word @0x20.
REQ-037 WAIT_CYCLES=3: assert rst during WAIT of a store -> no resp_valid_o, busy_o=0, subsequent load shows old data.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the pipeline memory stage. It accepts one
//   load/store at a time through a valid/ready handshake. After a fixed
//   number of wait states it returns a one-cycle response strobe with the
//   sign- or zero-extended load data.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array (power of two, >= 2)
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid_i       : request present
//   req_ready_o       : request can be accepted (IDLE only)
//   req_addr_i        : byte address
//   req_we_i          : 1 = store, 0 = load
//   req_wdata_i       : right-aligned store data
//   req_size_i        : 00 byte, 01 half, 10/11 word
//   req_unsigned_i    : 1 = zero-extend load, 0 = sign-extend
//   resp_valid_o      : one-cycle response strobe
//   resp_data_o       : extended load data (0 for stores / faults)
//   resp_err_o        : misalignment fault, qualified by resp_valid_o
//   busy_o            : access in flight
//
// Build option
//   DMEM_ALIGN_CHECK_EN : when defined, misaligned half/word accesses fault
//                         and do not write the array. When undefined, the
//                         offending low address bits are ignored.
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o,
   output logic        busy_o
);

   localparam int         AW         = $clog2(DEPTH_WORDS);
   localparam int         CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Request fields captured at acceptance. Address bits above the word
   // index are not needed because the index wraps modulo DEPTH_WORDS.
   typedef struct packed {
      logic [AW+1:0] addr;
      logic          we;
      logic [31:0]   wdata;
      logic [1:0]    size;
      logic          uns;
   } req_t;

   state_t      state, nxt;
   logic [3:0]  cnt;
   req_t        q;
   logic        accept;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] idx;
   logic [1:0]    ofs;
   logic          misalign;
   logic [3:0]    be;
   logic [31:0]   sdata;
   logic [31:0]   word;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   ext;

   // Upper address bits are intentionally dropped (silent wrap).
   logic unused_addr;
   assign unused_addr = ^req_addr_i[31:AW+2];

   assign accept = req_valid_i && req_ready_o;

   // ---------------- FSM state register, counter and request latch ----------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            q   <= '{addr: req_addr_i[AW+1:0], we: req_we_i, wdata: req_wdata_i,
                     size: req_size_i, uns: req_unsigned_i};
            cnt <= CNT_INIT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // ---------------- FSM next state / control outputs ----------------------
   always_comb begin
      nxt          = state;
      req_ready_o  = 1'b0;
      busy_o       = 1'b1;
      resp_valid_o = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (req_valid_i) nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
         end
         WAIT: if (cnt == 4'd0) nxt = RESP;
         RESP: begin
            resp_valid_o = 1'b1;
            nxt          = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // ---------------- Datapath ----------------------------------------------
   assign idx = q.addr[AW+1:2];
   assign ofs = q.addr[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = (q.size == 2'b01 && ofs[0]) || (q.size[1] && ofs != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Store lanes. Narrow data is replicated across lanes so that the byte
   // enables alone pick the destination.
   always_comb begin
      be    = 4'b1111;
      sdata = q.wdata;
      case (q.size)
         2'b00: begin
            be    = 4'b0001 << ofs;
            sdata = {4{q.wdata[7:0]}};
         end
         2'b01: begin
            be    = ofs[1] ? 4'b1100 : 4'b0011;
            sdata = {2{q.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // The load path reads the array combinationally in RESP. A store commits
   // on the edge leaving RESP, so the next access always sees it.
   assign word   = mem[idx];
   assign lane_b = 8'(word >> {ofs, 3'b000});
   assign lane_h = ofs[1] ? word[31:16] : word[15:0];

   always_comb begin
      ext = word;
      case (q.size)
         2'b00:   ext = q.uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   ext = q.uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: ;
      endcase
   end

   assign resp_data_o = (state == RESP && !q.we && !misalign) ? ext : 32'b0;
   assign resp_err_o  = (state == RESP) && misalign;

   // The array has no reset. An asynchronous reset forces IDLE before the
   // write edge, so an aborted store never lands.
   always_ff @(posedge clk) begin
      if (state == RESP && q.we && !misalign) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= sdata[8*i +: 8];
         end
      end
   end

endmodule
